// File: rtl/aib_txdp_pkg.sv
// Shared definitions for the TX adapter datapath FIFO read controller.
// Recovery after underflow is selected with AIB_TXDP_UFLOW_RECOVER_EN.
package aib_txdp_pkg;

  localparam int unsigned RdStateW = 2;

  typedef enum logic [RdStateW-1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StRun  = 2'd2,
    StErr  = 2'd3
  } rd_state_e;

endpackage

// File: rtl/aib_txdp_onehot_mux.sv
// AND-OR selector: picks the entry whose bit is set in a one-hot select vector.
module aib_txdp_onehot_mux #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DWIDTH = 80
) (
  input  logic [DEPTH-1:0]        sel_i,
  input  logic [DEPTH*DWIDTH-1:0] data_i,
  output logic [DWIDTH-1:0]       dout_o
);

  always_comb begin
    dout_o = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      dout_o = dout_o | (data_i[i*DWIDTH +: DWIDTH] & {DWIDTH{sel_i[i]}});
    end
  end

endmodule

// File: rtl/aib_adapttxdp_fifo_rdctl.sv
// Read-side controller of the TX datapath phase-compensation FIFO (read clock domain).
// Define AIB_TXDP_UFLOW_RECOVER_EN to let the ERR state fall back to FILL automatically.
module aib_adapttxdp_fifo_rdctl
  import aib_txdp_pkg::*;
#(
  parameter int unsigned AWIDTH = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DWIDTH = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_en,
  input  logic [AWIDTH-1:0]       cfg_rd_delay,
  input  logic [AWIDTH-1:0]       rd_numdata,
  input  logic                    rd_empty,
  input  logic [DEPTH-1:0]        rd_ptr_one_hot,
  input  logic [DEPTH*DWIDTH-1:0] fifo_data,
  output logic                    rd_en,
  output logic [DWIDTH-1:0]       dout,
  output logic                    dout_vld,
  output logic                    fifo_uflow,
  output logic [1:0]              rd_state
);

  rd_state_e         state_q, state_d;
  logic              uflow_q, uflow_d;
  logic [DWIDTH-1:0] dout_q, sel_word;
  logic              vld_q;
  logic [AWIDTH-1:0] threshold;
  logic              fill_met;

  assign threshold = (cfg_rd_delay == '0) ? AWIDTH'(1) : cfg_rd_delay;
  assign fill_met  = (rd_numdata >= threshold);

  // Gating by rd_empty keeps the read pointer from overtaking the write pointer.
  assign rd_en = (state_q == StRun) && !rd_empty;

  always_comb begin
    state_d = state_q;
    uflow_d = uflow_q;
    unique case (state_q)
      StIdle: state_d = StFill;
      StFill: if (fill_met) state_d = StRun;
      StRun: begin
        if (rd_empty) begin
          state_d = StErr;
        end
      end
      StErr: begin
`ifdef AIB_TXDP_UFLOW_RECOVER_EN
        state_d = StFill;
`else
        state_d = StErr;
`endif
      end
      default: state_d = StIdle;
    endcase
    if (!cfg_en) begin
      state_d = StIdle;
    end
    // An underflow coinciding with disable still shows for one cycle.
    if ((state_q == StRun) && rd_empty) begin
      uflow_d = 1'b1;
    end else if (!cfg_en) begin
      uflow_d = 1'b0;
    end
  end

  aib_txdp_onehot_mux #(
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH)
  ) u_mux (
    .sel_i (rd_ptr_one_hot),
    .data_i(fifo_data),
    .dout_o(sel_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      uflow_q <= 1'b0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      uflow_q <= uflow_d;
      vld_q   <= rd_en;
      if (rd_en) begin
        dout_q <= sel_word;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_vld   = vld_q;
  assign fifo_uflow = uflow_q;
  assign rd_state   = state_q;

endmodule

// File: tb/tb_aib_adapttxdp_fifo_rdctl.sv
// Self-checking bench for aib_adapttxdp_fifo_rdctl against a cycle-level behavioural model.
module tb_aib_adapttxdp_fifo_rdctl;

  localparam int unsigned AWIDTH = 4;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned DWIDTH = 80;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_en;
  logic [AWIDTH-1:0]       cfg_rd_delay;
  logic [AWIDTH-1:0]       rd_numdata;
  logic                    rd_empty;
  logic [DEPTH-1:0]        rd_ptr_one_hot;
  logic [DEPTH*DWIDTH-1:0] fifo_data;
  logic                    rd_en;
  logic [DWIDTH-1:0]       dout;
  logic                    dout_vld;
  logic                    fifo_uflow;
  logic [1:0]              rd_state;

  // Environment: FIFO storage plus a read pointer that advances on each read.
  logic [DWIDTH-1:0] mem [DEPTH];
  int unsigned       ptr;

  // Reference model (states: 0 idle, 1 filling, 2 streaming, 3 underflowed).
  int unsigned       m_state;
  logic              m_uflow;
  logic              m_vld;
  logic [DWIDTH-1:0] m_dout;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  always_comb begin
    fifo_data = '0;
    for (int i = 0; i < int'(DEPTH); i++) fifo_data[i*DWIDTH +: DWIDTH] = mem[i];
  end
  assign rd_ptr_one_hot = DEPTH'(1) << ptr;

  aib_adapttxdp_fifo_rdctl #(
    .AWIDTH(AWIDTH),
    .DEPTH (DEPTH),
    .DWIDTH(DWIDTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_en        (cfg_en),
    .cfg_rd_delay  (cfg_rd_delay),
    .rd_numdata    (rd_numdata),
    .rd_empty      (rd_empty),
    .rd_ptr_one_hot(rd_ptr_one_hot),
    .fifo_data     (fifo_data),
    .rd_en         (rd_en),
    .dout          (dout),
    .dout_vld      (dout_vld),
    .fifo_uflow    (fifo_uflow),
    .rd_state      (rd_state)
  );

  function automatic logic [DWIDTH-1:0] rand_word();
    return DWIDTH'({$urandom(), $urandom(), $urandom()});
  endfunction

  function automatic logic model_rden();
    return (m_state == 2) && !rd_empty;
  endfunction

  // Advance one clock; model and pointer logic update from the pre-edge inputs.
  task automatic tick();
    logic rden, r, en, emp;
    int   thr, num;
    rden = model_rden();
    r    = rst;
    en   = cfg_en;
    emp  = rd_empty;
    num  = int'(rd_numdata);
    thr  = (cfg_rd_delay == 0) ? 1 : int'(cfg_rd_delay);
    @(posedge clk);
    if (r) begin
      m_state = 0;
      m_uflow = 1'b0;
      m_vld   = 1'b0;
      m_dout  = '0;
    end else begin
      m_vld = rden;
      if (rden) m_dout = mem[ptr];
      if (m_state == 2 && emp) m_uflow = 1'b1;
      else if (!en) m_uflow = 1'b0;
      if (!en) m_state = 0;
      else if (m_state == 0) m_state = 1;
      else if (m_state == 1) begin
        if (num >= thr) m_state = 2;
      end else if (m_state == 2) begin
        if (emp) m_state = 3;
      end else begin
`ifdef AIB_TXDP_UFLOW_RECOVER_EN
        m_state = 1;
`else
        m_state = 3;
`endif
      end
    end
    #1;
    if (rden) begin
      mem[ptr] = rand_word();
      ptr = (ptr + 1) % DEPTH;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cfg_en = 1'b1;
    repeat (3) tick();
    n_cmp += 5;
    if (rd_state !== 2'd0) begin n_bad++; $display("FAIL reset_state got %0d want 0", rd_state); end
    if (rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_rd_en got %b want 0", rd_en); end
    if (dout !== '0) begin n_bad++; $display("FAIL reset_dout got %h want 0", dout); end
    if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got %b want 0", dout_vld); end
    if (fifo_uflow !== 1'b0) begin n_bad++; $display("FAIL reset_uflow got %b want 0", fifo_uflow); end
    rst = 1'b0;
  endtask

  task automatic test_fill_threshold();
    cfg_en = 1'b1;
    cfg_rd_delay = 4'd4;
    rd_empty = 1'b0;
    rd_numdata = 4'd0;
    tick();
    for (int n = 0; n <= 5; n++) begin
      rd_numdata = 4'(n);
      #1;
      n_cmp++;
      if (rd_en !== (n == 5)) begin
        n_bad++;
        $display("FAIL fill_rd_en numdata=%0d got %b want %b", n, rd_en, (n == 5));
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp += 2;
      if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL fill_vld got %b want 1", dout_vld); end
      if (dout !== m_dout) begin n_bad++; $display("FAIL fill_dout got %h want %h", dout, m_dout); end
      tick();
    end
  endtask

  task automatic test_zero_threshold();
    cfg_en = 1'b0;
    tick();
    cfg_en = 1'b1;
    cfg_rd_delay = 4'd0;
    rd_numdata = 4'd0;
    tick();
    tick();
    n_cmp++;
    if (rd_state !== 2'd1) begin n_bad++; $display("FAIL zero_thr_empty_state got %0d want 1", rd_state); end
    rd_numdata = 4'd1;
    tick();
    n_cmp++;
    if (rd_state !== 2'd2) begin n_bad++; $display("FAIL zero_thr_state got %0d want 2", rd_state); end
    #1;
    n_cmp++;
    if (rd_en !== 1'b1) begin n_bad++; $display("FAIL zero_thr_rd_en got %b want 1", rd_en); end
  endtask

  task automatic test_underflow();
    rd_empty = 1'b1;
    #1;
    n_cmp++;
    if (rd_en !== 1'b0) begin n_bad++; $display("FAIL uflow_rd_en got %b want 0", rd_en); end
    tick();
    n_cmp += 2;
    if (rd_state !== 2'd3) begin n_bad++; $display("FAIL uflow_state got %0d want 3", rd_state); end
    if (fifo_uflow !== 1'b1) begin n_bad++; $display("FAIL uflow_flag got %b want 1", fifo_uflow); end
    rd_empty = 1'b0;
    rd_numdata = 4'd0;
    tick();
`ifdef AIB_TXDP_UFLOW_RECOVER_EN
    n_cmp++;
    if (rd_state !== 2'd1) begin n_bad++; $display("FAIL uflow_recover got %0d want 1", rd_state); end
`else
    tick();
    n_cmp++;
    if (rd_state !== 2'd3) begin n_bad++; $display("FAIL uflow_terminal got %0d want 3", rd_state); end
`endif
    n_cmp++;
    if (fifo_uflow !== 1'b1) begin n_bad++; $display("FAIL uflow_sticky got %b want 1", fifo_uflow); end
    cfg_en = 1'b0;
    tick();
    n_cmp += 2;
    if (rd_state !== 2'd0) begin n_bad++; $display("FAIL uflow_exit got %0d want 0", rd_state); end
    if (fifo_uflow !== 1'b0) begin n_bad++; $display("FAIL uflow_clear got %b want 0", fifo_uflow); end
  endtask

  task automatic test_cfg_drop();
    cfg_en = 1'b1;
    cfg_rd_delay = 4'd2;
    rd_numdata = 4'd2;
    rd_empty = 1'b0;
    repeat (3) tick();
    cfg_en = 1'b0;
    #1;
    n_cmp++;
    if (rd_en !== 1'b1) begin n_bad++; $display("FAIL drop_last_rd_en got %b want 1", rd_en); end
    tick();
    n_cmp += 4;
    if (rd_state !== 2'd0) begin n_bad++; $display("FAIL drop_state got %0d want 0", rd_state); end
    if (rd_en !== 1'b0) begin n_bad++; $display("FAIL drop_rd_en got %b want 0", rd_en); end
    if (fifo_uflow !== 1'b0) begin n_bad++; $display("FAIL drop_uflow got %b want 0", fifo_uflow); end
    if (dout !== m_dout) begin n_bad++; $display("FAIL drop_dout got %h want %h", dout, m_dout); end
  endtask

  task automatic test_simultaneous();
    cfg_en = 1'b1;
    repeat (2) tick();
    rd_empty = 1'b1;
    cfg_en = 1'b0;
    tick();
    n_cmp += 2;
    if (rd_state !== 2'd0) begin n_bad++; $display("FAIL simul_state got %0d want 0", rd_state); end
    if (fifo_uflow !== 1'b1) begin n_bad++; $display("FAIL simul_uflow_set got %b want 1", fifo_uflow); end
    tick();
    n_cmp++;
    if (fifo_uflow !== 1'b0) begin n_bad++; $display("FAIL simul_uflow_clr got %b want 0", fifo_uflow); end
    rd_empty = 1'b0;
  endtask

  task automatic test_wrap();
    logic [DWIDTH-1:0] expq [$];
    cfg_en = 1'b1;
    rd_numdata = 4'd15;
    repeat (2) tick();
    for (int k = 0; k < 40; k++) begin
      expq.push_back(mem[ptr]);
      tick();
      n_cmp += 2;
      if (dout_vld !== 1'b1) begin n_bad++; $display("FAIL wrap_vld word=%0d got %b want 1", k, dout_vld); end
      if (dout !== expq[k]) begin
        n_bad++;
        $display("FAIL wrap_dout word=%0d got %h want %h", k, dout, expq[k]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp += 3;
    if (dout_vld !== 1'b0) begin n_bad++; $display("FAIL midrst_vld got %b want 0", dout_vld); end
    if (dout !== '0) begin n_bad++; $display("FAIL midrst_dout got %h want 0", dout); end
    if (rd_state !== 2'd0) begin n_bad++; $display("FAIL midrst_state got %0d want 0", rd_state); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      rst = ($urandom_range(0, 59) == 0);
      cfg_en = ($urandom_range(0, 24) != 0);
      cfg_rd_delay = 4'($urandom_range(0, 15));
      rd_numdata = 4'($urandom_range(0, 15));
      rd_empty = ($urandom_range(0, 9) == 0);
      #1;
      n_cmp++;
      if (rd_en !== model_rden()) begin
        n_bad++;
        $display("FAIL rand_rd_en cyc=%0d got %b want %b", k, rd_en, model_rden());
      end
      tick();
      n_cmp += 4;
      if (rd_state !== 2'(m_state)) begin
        n_bad++;
        $display("FAIL rand_state cyc=%0d got %0d want %0d", k, rd_state, m_state);
      end
      if (fifo_uflow !== m_uflow) begin
        n_bad++;
        $display("FAIL rand_uflow cyc=%0d got %b want %b", k, fifo_uflow, m_uflow);
      end
      if (dout_vld !== m_vld) begin
        n_bad++;
        $display("FAIL rand_vld cyc=%0d got %b want %b", k, dout_vld, m_vld);
      end
      if (dout !== m_dout) begin
        n_bad++;
        $display("FAIL rand_dout cyc=%0d got %h want %h", k, dout, m_dout);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    cfg_en = 1'b0;
    cfg_rd_delay = '0;
    rd_numdata = '0;
    rd_empty = 1'b0;
    ptr = 0;
    m_state = 0;
    m_uflow = 1'b0;
    m_vld = 1'b0;
    m_dout = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = rand_word();
    #1;
    test_reset();
    test_fill_threshold();
    test_zero_threshold();
    test_underflow();
    test_cfg_drop();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aib_adapttxdp_fifo_rdctl.md
# aib_adapttxdp_fifo_rdctl

Read-side controller for the TX adapter datapath phase-compensation FIFO, the consuming end of the dual-clock FIFO pointer logic. It lives entirely in the FIFO read clock domain. It waits until the FIFO holds a programmed fill level, then streams one word per cycle. It selects the word through the one-hot read pointer, registers it with a valid strobe, and flags underflow.

## Interface
Parameters:
- AWIDTH, 4, FIFO address width.
- DEPTH, 16, FIFO entries; must equal 1<<AWIDTH.
- DWIDTH, 80, data word width.

Ports:
- clk  in  1  read-domain clock.
- rst  in  1  reset; synchronous to clk, active-high.
- cfg_en  in  1  enable streaming; low forces IDLE.
- cfg_rd_delay  in  AWIDTH  fill threshold in words; 0 treated as 1.
- rd_numdata  in  AWIDTH  words available, from pointer logic.
- rd_empty  in  1  FIFO empty, registered upstream.
- rd_ptr_one_hot  in  DEPTH  current read pointer, one-hot.
- fifo_data  in  DEPTH*DWIDTH  flattened storage; entry i at [i*DWIDTH +: DWIDTH].
- rd_en  out  1  read strobe to pointer logic.
- dout  out  DWIDTH  registered read data.
- dout_vld  out  1  dout holds a new word this cycle.
- fifo_uflow  out  1  sticky underflow flag.
- rd_state  out  2  FSM state: IDLE=0, FILL=1, RUN=2, ERR=3.

## Operation
FSM:
- IDLE: rd_en=0. Goes to FILL when cfg_en=1.
- FILL: rd_en=0. Goes to RUN when rd_numdata >= max(cfg_rd_delay,1).
- RUN: rd_en = ~rd_empty.
  - If rd_empty=1, go to ERR and set fifo_uflow.
  - rd_en is gated by rd_empty, so the pointer never advances past the write pointer.
- ERR: rd_en=0. Exit behaviour is set by the macro (see Configuration).
- In any state, cfg_en=0 returns to IDLE next cycle. This takes priority over all other transitions.

Data path:
- When rd_en=1: dout <= OR over i of (rd_ptr_one_hot[i] ? entry i : 0), and dout_vld <= 1.
- Otherwise: dout holds its value and dout_vld <= 0.

fifo_uflow:
- Set on the RUN-to-ERR transition.
- Cleared only by rst, or by cfg_en=0 (takes effect when IDLE is entered).

Compare and threshold arithmetic is unsigned AWIDTH-bit. rd_numdata is never extended or wrapped inside this block.

## Timing
- Reset values: rd_state=IDLE, rd_en=0, dout=0, dout_vld=0, fifo_uflow=0.
- rd_en is combinational from the state register and rd_empty only. It has no path from rd_numdata, which avoids a loop through the pointer logic's next-pointer arithmetic.
- Latency: word selected in cycle N (rd_en=1) appears on dout with dout_vld=1 in cycle N+1.
- FILL-to-RUN: threshold met in cycle N; first rd_en in cycle N+1.
- Simultaneous rd_empty=1 and cfg_en=0 in RUN: go to IDLE, and fifo_uflow is still set for that one cycle before it clears.
- rst asserted mid-stream: all outputs reach reset values at the next edge; any word in flight is dropped.
- Full FIFO (rd_numdata = DEPTH-1 saturation) needs no special handling; RUN consumes every cycle.

## Configuration
- Macro AIB_TXDP_UFLOW_RECOVER_EN.
- Defined: ERR goes to FILL on the next cycle, so streaming resumes automatically after refill. fifo_uflow stays sticky.
- Undefined: ERR is terminal until cfg_en=0 or rst.

## Structure
- Shared package aib_txdp_pkg holds the FSM state encodings (IDLE/FILL/RUN/ERR, 2 bits).
- One sub-module, aib_txdp_onehot_mux: a parameterised (DEPTH, DWIDTH) AND-OR one-hot selector, purely combinational. The output register stays in the parent.

## Test plan
- Reset: rst=1 for 3 cycles → all outputs 0, rd_state=0.
- Fill threshold: cfg_rd_delay=4, rd_numdata ramps 0..5 → rd_en first rises the cycle after rd_numdata=4. dout matches the entry selected by the one-hot pointer, one cycle later.
- Zero threshold: cfg_rd_delay=0, rd_numdata=1 → RUN entered after 1 word, same as cfg_rd_delay=1.
- Underflow in RUN: drive rd_empty=1 → rd_en=0 that cycle, ERR next cycle, fifo_uflow=1.
  - With AIB_TXDP_UFLOW_RECOVER_EN: FILL the following cycle.
  - Without it: stays in ERR until cfg_en=0.
- cfg_en drop mid-stream: drop cfg_en while in RUN → IDLE next cycle, rd_en=0, fifo_uflow cleared.
- Pointer wrap: stream 40 words with DEPTH=16 → dout sequence is correct across the wrap from pointer 15 to 0, with no dout_vld gaps.
